// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: LC-3 memory-access stage. Holds MAR/MDR and a word-addressed
// memory with a fixed access latency, and signals completion to control via R.
module lc3_mem_ctrl #(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 256,
    parameter int MEM_LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              ld_mar,
    input  logic              ld_mdr,
    input  logic              mio_en,
    input  logic              r_w,
    output logic [DATA_W-1:0] mar_out,
    output logic [DATA_W-1:0] mdr_out,
    output logic              r,
    output logic              busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              start, finish;
    logic [AW-1:0]     addr_q;
    logic              op_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] mar, mdr;
    logic [DATA_W-1:0] mem [DEPTH];

    assign mar_out = mar;
    assign mdr_out = mdr;

    // Next-state and latency countdown; start/finish mark the access edges.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        start    = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                if (mio_en) begin
                    state_nx = BUSY;
                    cnt_nx   = CNT_INIT;
                    start    = 1'b1;
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    state_nx = DONE;
                    finish   = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State, counter and registered R/busy decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            r     <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            r     <= (state_nx == DONE);
            busy  <= (state_nx != IDLE);
        end
    end

    // Snapshot address/op/write data at access start; capture read data at completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            op_q    <= 1'b0;
            wdata_q <= '0;
            rd_q    <= '0;
        end else begin
            if (start) begin
                addr_q  <= mar[AW-1:0];
                op_q    <= r_w;
                wdata_q <= mdr;
            end
            if (finish && !op_q) begin
                rd_q <= mem[addr_q];
            end
        end
    end

    // Memory array is not reset; a write commits only on the BUSY->DONE edge.
    always_ff @(posedge clk) begin
        if (finish && op_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

    // MAR loads from the bus in any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mar <= '0;
        end else if (ld_mar) begin
            mar <= bus_in;
        end
    end

    // MDR loads from the bus when memory is idle, or from read data on R.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdr <= '0;
        end else if (ld_mdr) begin
            if (!mio_en) begin
                mdr <= bus_in;
            end else if (r) begin
                mdr <= rd_q;
            end
        end
    end

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// tb_lc3_mem_ctrl: randomized scoreboard bench for lc3_mem_ctrl with a
// behavioural memory model; extra instances cover the latency extremes.
module tb_lc3_mem_ctrl;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bus_in = '0;
    logic        ld_mar = 1'b0, ld_mdr = 1'b0, mio_en = 1'b0, r_w = 1'b0;
    logic [15:0] mar_out, mdr_out;
    logic        r, busy;

    logic [15:0] l_bus = '0;
    logic        l_ld_mar = 1'b0, l_ld_mdr = 1'b0, l_mio = 1'b0, l_rw = 1'b0;
    logic [15:0] mar1, mdr1, mar15, mdr15;
    logic        r1, busy1, r15, busy15;

    always #5 clk = ~clk;

    lc3_mem_ctrl #(.DATA_W(16), .DEPTH(256), .MEM_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
        .mio_en(mio_en), .r_w(r_w), .mar_out(mar_out), .mdr_out(mdr_out), .r(r), .busy(busy));

    lc3_mem_ctrl #(.DATA_W(16), .DEPTH(256), .MEM_LATENCY(1)) dl1 (
        .clk(clk), .rst_n(rst_n), .bus_in(l_bus), .ld_mar(l_ld_mar), .ld_mdr(l_ld_mdr),
        .mio_en(l_mio), .r_w(l_rw), .mar_out(mar1), .mdr_out(mdr1), .r(r1), .busy(busy1));

    lc3_mem_ctrl #(.DATA_W(16), .DEPTH(256), .MEM_LATENCY(15)) dl15 (
        .clk(clk), .rst_n(rst_n), .bus_in(l_bus), .ld_mar(l_ld_mar), .ld_mdr(l_ld_mdr),
        .mio_en(l_mio), .r_w(l_rw), .mar_out(mar15), .mdr_out(mdr15), .r(r15), .busy(busy15));

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: memory contents and architectural MAR/MDR.
    logic [15:0] ref_mem [256];
    int          wlist[$];
    logic [15:0] m_mar = '0, m_mdr = '0;

    typedef struct {
        int          start;
        bit          cap;
        logic [15:0] exp;
    } sb_t;
    sb_t sbq[$];

    bit          mon_en = 1'b0;
    bit          pend = 1'b0;
    logic [15:0] pend_val;
    int          busy_cnt = 0;

    // Monitor: on each R pulse pop the scoreboard, check latency, busy length and captured MDR.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (pend) begin
                chk("mdr_after_read", {16'h0, mdr_out}, {16'h0, pend_val});
                pend = 1'b0;
            end
            if (r === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_r", {31'h0, r}, 32'h0);
                end else begin
                    sb_t e;
                    e = sbq.pop_front();
                    chk("r_latency", cyc - e.start, L);
                    if (e.cap) begin
                        pend     = 1'b1;
                        pend_val = e.exp;
                    end
                end
            end
            if (busy === 1'b1) busy_cnt++;
            else if (busy_cnt > 0) begin
                chk("busy_len", busy_cnt, L + 1);
                busy_cnt = 0;
            end
        end else begin
            busy_cnt = 0;
            pend     = 1'b0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_mar(input logic [15:0] v);
        bus_in = v; ld_mar = 1'b1;
        tick();
        ld_mar = 1'b0; m_mar = v;
        chk("mar_load", {16'h0, mar_out}, {16'h0, m_mar});
    endtask

    task automatic load_mdr(input logic [15:0] v);
        bus_in = v; ld_mdr = 1'b1; mio_en = 1'b0;
        tick();
        ld_mdr = 1'b0; m_mdr = v;
        chk("mdr_load", {16'h0, mdr_out}, {16'h0, m_mdr});
    endtask

    // One access using current MAR/MDR; optional mid-access MAR/r_w scramble and mio_en drop.
    task automatic access(input bit rw, input bit scr, input logic [15:0] scr_val,
                          input bit drop, input bit cap);
        int          idx;
        int          n;
        bit          seen;
        bit          docap;
        logic [15:0] exp;
        idx   = int'(m_mar[7:0]);
        docap = !rw && cap && !drop;
        mio_en = 1'b1; r_w = rw; ld_mdr = docap;
        tick();
        exp = rw ? m_mdr : ref_mem[idx];
        sbq.push_back('{cyc, docap, exp});
        if (rw) begin
            ref_mem[idx] = m_mdr;
            wlist.push_back(idx);
        end
        if (drop) mio_en = 1'b0;
        if (scr) begin
            bus_in = scr_val; ld_mar = 1'b1; r_w = ~rw;
            tick();
            ld_mar = 1'b0; m_mar = scr_val;
        end
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (r === 1'b1) seen = 1'b1;
            else chk("mdr_hold_busy", {16'h0, mdr_out}, {16'h0, m_mdr});
        end
        if (!seen) chk("r_timeout", {31'h0, seen}, 32'h1);
        tick();
        mio_en = 1'b0; ld_mdr = 1'b0; r_w = 1'b0;
        if (docap) m_mdr = exp;
        chk("mar_after_access", {16'h0, mar_out}, {16'h0, m_mar});
    endtask

    initial begin
        int s;
        int f1, f15, c1, c15;
        // Reset and idle
        repeat (2) tick();
        chk("rst_mar", {16'h0, mar_out}, 32'h0);
        chk("rst_mdr", {16'h0, mdr_out}, 32'h0);
        chk("rst_r", {31'h0, r}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        rst_n = 1'b1; mon_en = 1'b1;
        tick();

        // Asynchronous reset clears before the next edge
        load_mar(16'hFFFF);
        load_mdr(16'h1234);
        #2 rst_n = 1'b0;
        #1;
        chk("async_mar", {16'h0, mar_out}, 32'h0);
        chk("async_mdr", {16'h0, mdr_out}, 32'h0);
        tick();
        rst_n = 1'b1; m_mar = '0; m_mdr = '0;
        tick();

        // Write then read back
        load_mar(16'h0010);
        load_mdr(16'hBEEF);
        access(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        load_mdr(16'h0000);
        access(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        chk("readback_beef", {16'h0, mdr_out}, 32'hBEEF);

        // Aliasing, and MAR change mid-access does not redirect it
        load_mar(16'h0110);
        load_mdr(16'h1234);
        access(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        load_mar(16'h0010);
        load_mdr(16'h0000);
        access(1'b0, 1'b1, 16'h0020, 1'b0, 1'b1);
        chk("alias_read", {16'h0, mdr_out}, 32'h1234);
        chk("alias_mar", {16'h0, mar_out}, 32'h0020);

        // Abort: reset in BUSY drops the pending write
        load_mar(16'h0030);
        load_mdr(16'hAAAA);
        access(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        load_mdr(16'h5555);
        mio_en = 1'b1; r_w = 1'b1;
        tick();
        mio_en = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        repeat (2) tick();
        rst_n = 1'b1; m_mar = '0; m_mdr = '0;
        repeat (L + 2) begin
            @(negedge clk);
            chk("abort_no_r", {31'h0, r}, 32'h0);
        end
        tick();
        load_mar(16'h0030);
        load_mdr(16'h0000);
        access(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        chk("abort_read", {16'h0, mdr_out}, 32'hAAAA);

        // Randomized accesses against the model
        for (int i = 0; i < 40; i++) begin
            bit          rw, scr, drop;
            logic [15:0] sv;
            rw   = ($urandom_range(0, 1) == 1);
            scr  = ($urandom_range(0, 3) == 0);
            drop = ($urandom_range(0, 3) == 0);
            sv   = 16'($urandom);
            if (rw) begin
                load_mar(16'($urandom));
                load_mdr(16'($urandom));
                access(1'b1, scr, sv, drop, 1'b0);
            end else begin
                int idx;
                idx = wlist[$urandom_range(0, wlist.size() - 1)];
                load_mar({8'($urandom), 8'(idx)});
                if ($urandom_range(0, 1) == 1) load_mdr(16'($urandom));
                access(1'b0, scr, sv, drop, 1'b1);
            end
        end

        // Latency extremes, mio_en dropped after the start edge
        l_bus = 16'h0005; l_ld_mar = 1'b1;
        tick();
        l_ld_mar = 1'b0; l_bus = 16'h7777; l_ld_mdr = 1'b1;
        tick();
        l_ld_mdr = 1'b0;
        chk("lat_mar1", {16'h0, mar1}, 32'h0005);
        chk("lat_mdr15", {16'h0, mdr15}, 32'h7777);
        l_mio = 1'b1; l_rw = 1'b1;
        tick();
        s = cyc;
        l_mio = 1'b0; l_rw = 1'b0;
        f1 = -1; f15 = -1; c1 = 0; c15 = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (r1 === 1'b1) begin c1++; if (f1 < 0) f1 = cyc - s; end
            if (r15 === 1'b1) begin c15++; if (f15 < 0) f15 = cyc - s; end
        end
        chk("lat1_delay", f1, 1);
        chk("lat1_pulses", c1, 1);
        chk("lat15_delay", f15, 15);
        chk("lat15_pulses", c15, 1);

        tick();
        chk("sb_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lc3_mem_ctrl.md
Name: lc3_mem_ctrl

Overview:
Memory-access stage of the LC-3 datapath. Holds MAR and MDR, owns a word-addressed memory array with a fixed multi-cycle access latency, and raises the LC-3 R (ready) signal to the control unit. Its mdr_out feeds the GateMDR bus tribuffer directly downstream, which places MDR onto the shared 16-bit bus. bus_in is the shared bus value.

Parameters:
DATA_W, 16, bus, MAR and MDR width
DEPTH, 256, memory words; index = MAR[$clog2(DEPTH)-1:0], upper MAR bits ignored (aliasing)
MEM_LATENCY, 4, cycles from access start to R; legal range 1..15

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
bus_in  input  DATA_W  shared bus value
ld_mar  input  1  load MAR from bus_in
ld_mdr  input  1  load MDR: from bus_in when mio_en=0; from memory read data when mio_en=1 and r=1
mio_en  input  1  memory access request (held by control until r)
r_w  input  1  1 = write, 0 = read; sampled at access start
mar_out  output  DATA_W  MAR contents
mdr_out  output  DATA_W  MDR contents, to GateMDR tribuffer
r  output  1  ready, one-cycle pulse at access completion
busy  output  1  high while an access is in flight (BUSY or DONE)

Behaviour:
- Reset (async, rst_n=0): MAR=0, MDR=0, state=IDLE, cnt=0, rd_q=0, r=0, busy=0. Memory array not cleared. Reset mid-access aborts it; a pending write is not committed.
- MAR: ld_mar=1 at edge -> MAR<=bus_in. Independent of the state machine; legal in any state.
- MDR: ld_mdr=1 and mio_en=0 -> MDR<=bus_in. ld_mdr=1, mio_en=1, r=1 -> MDR<=rd_q. ld_mdr=1, mio_en=1, r=0 -> MDR holds.
- States: IDLE, BUSY, DONE.
- IDLE: mio_en=1 at edge t0 -> latch addr_q=MAR index, op_q=r_w, wdata_q=MDR; cnt<=MEM_LATENCY-1; go BUSY.
- BUSY: at each edge, cnt==0 -> go DONE; otherwise cnt<=cnt-1. DONE is entered at edge t0+MEM_LATENCY.
- On the BUSY->DONE edge: write (op_q=1) -> mem[addr_q]<=wdata_q. Read -> rd_q<=mem[addr_q].
- DONE: r=1 for exactly this one cycle. Next edge goes IDLE unconditionally.
- r and busy are registered outputs, decoded from state. busy=1 in BUSY and DONE.
- A new access needs mio_en=1 while in IDLE, so back-to-back accesses have at least one IDLE cycle between r pulses.
- Once started, an access always completes:
  - MAR/MDR/r_w changes after t0 have no effect on the access.
  - mio_en dropping mid-access does not abort; r still pulses.
- Read after write to the same address returns the written value. ld_mar and ld_mdr may be asserted in the same cycle.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles -> mar_out=0x0000, mdr_out=0x0000, r=0, busy=0; async: outputs clear before next clk edge.
- Write: bus=0x0010+ld_mar; bus=0xBEEF+ld_mdr; mio_en=1,r_w=1 held until r -> r pulses exactly 4 cycles after start edge for 1 cycle, busy high 5 cycles.
- Read back: MAR=0x0010, mio_en=1,r_w=0,ld_mdr=1 until r -> MDR=0xBEEF on edge ending r cycle; MDR unchanged (still prior value) during BUSY.
- Aliasing/isolation: write 0x1234 at MAR=0x0110 (DEPTH=256) -> read at 0x0010 returns 0x1234; change MAR to 0x0020 mid-access -> access still uses 0x0010.
- Abort: start write of 0x5555 to 0x0030 (prior 0xAAAA), assert rst_n=0 in BUSY cycle 2 -> r never pulses; later read of 0x0030 returns 0xAAAA.
- Latency sweep: MEM_LATENCY=1 and 15 -> r exactly 1 and 15 cycles after start edge; mio_en dropped after 1 cycle still yields r pulse.
